// File: rtl/paddle_ctrl_if.sv
// Purpose: bundles the paddle controller's frame/button inputs and paddle outputs.
// Ports (signals):
//   refresh_tick, game_over          frame pulse and hold-centred request
//   btn_up1, btn_dn1, btn_up2, btn_dn2  raw asynchronous push-buttons
//   paddle1_y, paddle2_y             paddle top rows (10 bit)
//   paddle1_dir, paddle2_dir         FSM state: 00 idle, 01 up, 10 down
// Modports: master drives the inputs (ball block / board), slave is the controller.
interface paddle_ctrl_if;
  logic       refresh_tick;
  logic       game_over;
  logic       btn_up1;
  logic       btn_dn1;
  logic       btn_up2;
  logic       btn_dn2;
  logic [9:0] paddle1_y;
  logic [9:0] paddle2_y;
  logic [1:0] paddle1_dir;
  logic [1:0] paddle2_dir;

  modport master (
    output refresh_tick, game_over, btn_up1, btn_dn1, btn_up2, btn_dn2,
    input  paddle1_y, paddle2_y, paddle1_dir, paddle2_dir
  );

  modport slave (
    input  refresh_tick, game_over, btn_up1, btn_dn1, btn_up2, btn_dn2,
    output paddle1_y, paddle2_y, paddle1_dir, paddle2_dir
  );
endinterface

// File: rtl/paddle_ctrl.sv
// Purpose: turns four raw push-buttons into two paddle positions. Each button is
// synchronised (2 FF) and debounced; each paddle runs an IDLE/UP/DOWN FSM stepped
// on refresh_tick, with a speed that ramps while the direction is held and a
// position that saturates inside the playfield.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high reset
//   bus    slave modport of paddle_ctrl_if (tick, game_over, buttons in; y/dir out)
module paddle_ctrl #(
  parameter int unsigned DEB_CYCLES = 250000,
  parameter int unsigned PADDLE_H   = 72,
  parameter int unsigned FIELD_H    = 455,
  parameter int unsigned MIN_SPEED  = 2,
  parameter int unsigned MAX_SPEED  = 6,
  parameter int unsigned RAMP_TICKS = 8
) (
  input logic          clk,
  input logic          reset,
  paddle_ctrl_if.slave bus
);

  localparam int unsigned Y_W      = 10;
  localparam int unsigned EXT_W    = 11;
  localparam int unsigned N_BTN    = 4;
  localparam int unsigned N_PAD    = 2;
  localparam int unsigned Y_MAX    = FIELD_H - PADDLE_H;
  localparam int unsigned Y_CENTRE = Y_MAX >> 1;
  localparam int unsigned DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned SPD_W    = $clog2(MAX_SPEED + 1);
  localparam int unsigned HOLD_W   = $clog2(RAMP_TICKS + 1);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_UP   = 2'b01;
  localparam logic [1:0] ST_DN   = 2'b10;

  // Button order: [0] up1, [1] dn1, [2] up2, [3] dn2.
  logic [N_BTN-1:0] w_raw;
  logic [N_BTN-1:0] r_s0;
  logic [N_BTN-1:0] r_s1;
  logic [N_BTN-1:0] r_deb;
  logic [DEB_W-1:0] r_cnt [N_BTN];

  logic [1:0]        r_state [N_PAD];
  logic [Y_W-1:0]    r_y     [N_PAD];
  logic [SPD_W-1:0]  r_spd   [N_PAD];
  logic [HOLD_W-1:0] r_hold  [N_PAD];

  logic [1:0]        w_state_nxt [N_PAD];
  logic [Y_W-1:0]    w_y_nxt     [N_PAD];
  logic [SPD_W-1:0]  w_spd_nxt   [N_PAD];
  logic [HOLD_W-1:0] w_hold_nxt  [N_PAD];
  logic [1:0]        w_tgt       [N_PAD];
  logic              w_enter     [N_PAD];
  logic [SPD_W-1:0]  w_spd_eff   [N_PAD];
  logic [HOLD_W-1:0] w_hold_inc  [N_PAD];
  logic [EXT_W-1:0]  w_y_ext     [N_PAD];
  logic [EXT_W-1:0]  w_spd_ext   [N_PAD];
  logic [EXT_W-1:0]  w_dn_sum    [N_PAD];

  assign w_raw = {bus.btn_dn2, bus.btn_up2, bus.btn_dn1, bus.btn_up1};

  // Synchroniser and debounce: the level follows s1 only after DEB_CYCLES stable clocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s0  <= '0;
      r_s1  <= '0;
      r_deb <= '0;
      for (int b = 0; b < N_BTN; b++) r_cnt[b] <= '0;
    end else begin
      r_s0 <= w_raw;
      r_s1 <= r_s0;
      for (int b = 0; b < N_BTN; b++) begin
        if (r_s1[b] != r_deb[b]) begin
          if (r_cnt[b] == DEB_W'(DEB_CYCLES - 1)) begin
            r_deb[b] <= r_s1[b];
            r_cnt[b] <= '0;
          end else begin
            r_cnt[b] <= r_cnt[b] + DEB_W'(1);
          end
        end else begin
          r_cnt[b] <= '0;
        end
      end
    end
  end

  // Paddle state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < N_PAD; p++) begin
        r_state[p] <= ST_IDLE;
        r_y[p]     <= Y_W'(Y_CENTRE);
        r_spd[p]   <= SPD_W'(MIN_SPEED);
        r_hold[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < N_PAD; p++) begin
        r_state[p] <= w_state_nxt[p];
        r_y[p]     <= w_y_nxt[p];
        r_spd[p]   <= w_spd_nxt[p];
        r_hold[p]  <= w_hold_nxt[p];
      end
    end
  end

  // Next-state, movement and speed ramp per paddle.
  always_comb begin
    for (int p = 0; p < N_PAD; p++) begin
      w_state_nxt[p] = r_state[p];
      w_y_nxt[p]     = r_y[p];
      w_spd_nxt[p]   = r_spd[p];
      w_hold_nxt[p]  = r_hold[p];

      if (r_deb[2*p] && !r_deb[2*p+1])      w_tgt[p] = ST_UP;
      else if (r_deb[2*p+1] && !r_deb[2*p]) w_tgt[p] = ST_DN;
      else                                  w_tgt[p] = ST_IDLE;

      // A fresh direction (including a direct UP<->DOWN reversal) restarts the ramp
      // before this tick's move.
      w_enter[p]    = (w_tgt[p] != r_state[p]);
      w_spd_eff[p]  = w_enter[p] ? SPD_W'(MIN_SPEED) : r_spd[p];
      w_hold_inc[p] = w_enter[p] ? HOLD_W'(1) : (r_hold[p] + HOLD_W'(1));
      w_y_ext[p]    = {1'b0, r_y[p]};
      w_spd_ext[p]  = EXT_W'(w_spd_eff[p]);
      w_dn_sum[p]   = w_y_ext[p] + w_spd_ext[p];

      if (bus.game_over) begin
        w_state_nxt[p] = ST_IDLE;
        w_y_nxt[p]     = Y_W'(Y_CENTRE);
        w_spd_nxt[p]   = SPD_W'(MIN_SPEED);
        w_hold_nxt[p]  = '0;
      end else if (bus.refresh_tick) begin
        w_state_nxt[p] = w_tgt[p];
        if (w_tgt[p] == ST_IDLE) begin
          w_spd_nxt[p]  = SPD_W'(MIN_SPEED);
          w_hold_nxt[p] = '0;
        end else begin
          if (w_tgt[p] == ST_UP) begin
            w_y_nxt[p] = (w_y_ext[p] < w_spd_ext[p]) ? '0
                                                      : Y_W'(w_y_ext[p] - w_spd_ext[p]);
          end else begin
            w_y_nxt[p] = (w_dn_sum[p] > EXT_W'(Y_MAX)) ? Y_W'(Y_MAX) : Y_W'(w_dn_sum[p]);
          end
          if (w_hold_inc[p] == HOLD_W'(RAMP_TICKS)) begin
            w_spd_nxt[p]  = (w_spd_eff[p] >= SPD_W'(MAX_SPEED)) ? SPD_W'(MAX_SPEED)
                                                                 : (w_spd_eff[p] + SPD_W'(1));
            w_hold_nxt[p] = '0;
          end else begin
            w_spd_nxt[p]  = w_spd_eff[p];
            w_hold_nxt[p] = w_hold_inc[p];
          end
        end
      end
    end
  end

  assign bus.paddle1_y   = r_y[0];
  assign bus.paddle2_y   = r_y[1];
  assign bus.paddle1_dir = r_state[0];
  assign bus.paddle2_dir = r_state[1];

endmodule

// File: tb/tb_paddle_ctrl.sv
// Purpose: self-checking bench for paddle_ctrl. A behavioural model (button
// histories, run-length speed formula, clamped integer motion) predicts both
// paddles every clock; directed phases add fixed expectations at key points.
module tb_paddle_ctrl;

  localparam int DEB   = 4;
  localparam int RAMP  = 8;
  localparam int VMIN  = 2;
  localparam int VMAX  = 6;
  localparam int YMAX  = 383;
  localparam int YCTR  = 191;

  logic clk = 1'b0;
  logic reset;
  paddle_ctrl_if pif();

  paddle_ctrl #(
    .DEB_CYCLES(DEB), .PADDLE_H(72), .FIELD_H(455),
    .MIN_SPEED(VMIN), .MAX_SPEED(VMAX), .RAMP_TICKS(RAMP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (pif)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit last_tick;

  // Reference model state.
  int my   [2];
  int mdir [2];
  int mrun [2];
  bit ms0  [4];
  bit ms1  [4];
  bit mdeb [4];
  bit mseen[4][DEB];

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advances the model by one clock edge using the inputs presented at that edge.
  task automatic model_edge();
    bit raw [4];
    raw[0] = pif.btn_up1; raw[1] = pif.btn_dn1; raw[2] = pif.btn_up2; raw[3] = pif.btn_dn2;
    if (reset) begin
      for (int p = 0; p < 2; p++) begin my[p] = YCTR; mdir[p] = 0; mrun[p] = 0; end
      for (int b = 0; b < 4; b++) begin
        ms0[b] = 0; ms1[b] = 0; mdeb[b] = 0;
        for (int i = 0; i < DEB; i++) mseen[b][i] = 0;
      end
      return;
    end
    for (int p = 0; p < 2; p++) begin
      bit up, dn;
      int tgt, spd;
      up = mdeb[2*p]; dn = mdeb[2*p+1];
      if (pif.game_over) begin
        my[p] = YCTR; mdir[p] = 0; mrun[p] = 0;
      end else if (pif.refresh_tick) begin
        tgt = (up && !dn) ? 1 : ((dn && !up) ? 2 : 0);
        if (tgt == 0) begin
          mdir[p] = 0; mrun[p] = 0;
        end else begin
          if (tgt != mdir[p]) mrun[p] = 0;
          mrun[p]++;
          spd = VMIN + (mrun[p] - 1) / RAMP;
          if (spd > VMAX) spd = VMAX;
          if (tgt == 1) my[p] = (my[p] - spd < 0) ? 0 : my[p] - spd;
          else          my[p] = (my[p] + spd > YMAX) ? YMAX : my[p] + spd;
          mdir[p] = tgt;
        end
      end
    end
    // Debounced level flips once the last DEB synchronised samples all disagree with it.
    for (int b = 0; b < 4; b++) begin
      bit all_diff;
      for (int i = DEB - 1; i > 0; i--) mseen[b][i] = mseen[b][i-1];
      mseen[b][0] = ms1[b];
      all_diff = 1'b1;
      for (int i = 0; i < DEB; i++) if (mseen[b][i] == mdeb[b]) all_diff = 1'b0;
      if (all_diff) mdeb[b] = ~mdeb[b];
      ms1[b] = ms0[b];
      ms0[b] = raw[b];
    end
  endtask

  task automatic step();
    pif.refresh_tick = ((cyc % 10) == 9);
    last_tick = pif.refresh_tick;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("y1",   int'(pif.paddle1_y),   my[0]);
    chk("y2",   int'(pif.paddle2_y),   my[1]);
    chk("dir1", int'(pif.paddle1_dir), mdir[0]);
    chk("dir2", int'(pif.paddle2_dir), mdir[1]);
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       pif.btn_up1 = v;
      1:       pif.btn_dn1 = v;
      2:       pif.btn_up2 = v;
      default: pif.btn_dn2 = v;
    endcase
  endtask

  initial begin
    int k;
    bit cur [4];
    reset = 1'b1;
    pif.refresh_tick = 1'b0; pif.game_over = 1'b0;
    pif.btn_up1 = 1'b0; pif.btn_dn1 = 1'b0; pif.btn_up2 = 1'b0; pif.btn_dn2 = 1'b0;
    step_n(2);
    reset = 1'b0;
    chk("rst_y1", int'(pif.paddle1_y), YCTR);
    chk("rst_y2", int'(pif.paddle2_y), YCTR);
    chk("rst_dir1", int'(pif.paddle1_dir), 0);

    // Short glitch is rejected.
    pif.btn_up1 = 1'b1; step_n(3);
    pif.btn_up1 = 1'b0; step_n(30);
    chk("glitch_y1", int'(pif.paddle1_y), YCTR);

    // Held press: ramp 2,3,4,5 then saturate at 6.
    pif.btn_up1 = 1'b1;
    k = 0;
    while (pif.paddle1_dir != 2'b01 && k < 40) begin step(); k++; end
    chk("up1_start", int'(pif.paddle1_dir), 1);
    chk("first_move", int'(pif.paddle1_y), 189);
    step_n(70);  chk("ramp8",  int'(pif.paddle1_y), 175);
    step_n(80);  chk("ramp16", int'(pif.paddle1_y), 151);
    step_n(80);  chk("ramp24", int'(pif.paddle1_y), 119);
    step_n(80);  chk("ramp32", int'(pif.paddle1_y), 79);
    step_n(80);  chk("sat40",  int'(pif.paddle1_y), 31);
    step_n(100); chk("clamp0", int'(pif.paddle1_y), 0);
    chk("clamp_dir", int'(pif.paddle1_dir), 1);
    pif.btn_up1 = 1'b0; step_n(30);
    chk("rel_dir", int'(pif.paddle1_dir), 0);
    chk("rel_y",   int'(pif.paddle1_y), 0);

    // Bottom clamp, then both buttons freeze paddle 2.
    pif.btn_dn2 = 1'b1; step_n(500);
    chk("clamp383", int'(pif.paddle2_y), YMAX);
    chk("clamp383_dir", int'(pif.paddle2_dir), 2);
    pif.btn_up2 = 1'b1; step_n(30);
    chk("both_dir", int'(pif.paddle2_dir), 0);
    chk("both_y",   int'(pif.paddle2_y), YMAX);

    // game_over pulse mid-press recentres, then resumes at MIN speed.
    pif.btn_up2 = 1'b0; pif.btn_up1 = 1'b1; step_n(50);
    pif.game_over = 1'b1; step();
    pif.game_over = 1'b0;
    chk("go_y1", int'(pif.paddle1_y), YCTR);
    chk("go_y2", int'(pif.paddle2_y), YCTR);
    chk("go_dir1", int'(pif.paddle1_dir), 0);
    k = 0;
    do begin step(); k++; end while (!last_tick && k < 20);
    chk("resume_y1", int'(pif.paddle1_y), YCTR - VMIN);
    chk("resume_y2", int'(pif.paddle2_y), YCTR + VMIN);

    // Reset mid-press: recentre, then re-debounce before the next move.
    step_n(60);
    reset = 1'b1; step();
    reset = 1'b0;
    chk("midrst_y1", int'(pif.paddle1_y), YCTR);
    k = 0;
    while (pif.paddle1_y == 10'(YCTR) && k < 40) begin step(); k++; end
    chk("midrst_moved", int'(pif.paddle1_y), YCTR - VMIN);
    chk("midrst_delay_ok", int'(k >= DEB + 2), 1);

    // Random buttons, occasional game_over and reset.
    for (int b = 0; b < 4; b++) cur[b] = 1'b0;
    for (int b = 0; b < 4; b++) set_btn(b, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(29, 0) == 0) begin
        int b;
        b = int'($urandom_range(3, 0));
        cur[b] = ~cur[b];
        set_btn(b, cur[b]);
      end
      pif.game_over = ($urandom_range(299, 0) == 0);
      reset = ($urandom_range(1499, 0) == 0);
      step();
    end
    reset = 1'b0; pif.game_over = 1'b0;
    step_n(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
